// File: rtl/linear_regression_predict_mv_pkg.sv
// Shared types, default widths and result-formatting helpers for the
// multivariate linear-regression predictor.
package lr_pkg;

  localparam int LR_N_DEF    = 32;
  localparam int LR_K_DEF    = 4;
  localparam int LR_FRAC_DEF = 0;
  // Widest accumulator the formatting helpers can handle.
  localparam int LR_MAXW     = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } lr_state_t;

  function automatic int lr_acc_w(input int n, input int k);
    return 2 * n + $clog2(k + 1);
  endfunction

  function automatic logic lr_is_ovf(input logic signed [LR_MAXW-1:0] v, input int n);
    logic signed [LR_MAXW-1:0] hi;
    hi = v >>> (n - 1);
    return !((hi == '0) || (hi == '1));
  endfunction

  function automatic logic [LR_MAXW-1:0] lr_fit(input logic signed [LR_MAXW-1:0] v,
                                                input int n, input logic sat);
    logic [LR_MAXW-1:0] one;
    logic [LR_MAXW-1:0] min_v;
    one   = {{(LR_MAXW-1){1'b0}}, 1'b1};
    min_v = one << (n - 1);
    if (sat && lr_is_ovf(v, n)) return v[LR_MAXW-1] ? min_v : (min_v - one);
    return v;
  endfunction

endpackage

// File: rtl/linear_regression_predict_mv_if.sv
// Coefficient-load, feature-vector and prediction handshake bundle.
interface linear_regression_predict_mv_if #(
  parameter int N = 32,
  parameter int K = 4
);
  localparam int AW = $clog2(K + 1);

  logic              i_coef_wr;
  logic [AW-1:0]     i_coef_addr;
  logic [N-1:0]      i_coef_data;
  logic              i_coef_commit;
  logic [K*N-1:0]    i_samples_x_in;
  logic              i_samples_x_vld;
  logic              o_samples_x_rdy;
  logic [N-1:0]      o_predict_out;
  logic              o_predict_out_vld;
  logic              i_predict_out_rdy;
  logic              o_predict_ovf;

  modport slave (
    input  i_coef_wr, i_coef_addr, i_coef_data, i_coef_commit,
    input  i_samples_x_in, i_samples_x_vld, i_predict_out_rdy,
    output o_samples_x_rdy, o_predict_out, o_predict_out_vld, o_predict_ovf
  );

  modport master (
    output i_coef_wr, i_coef_addr, i_coef_data, i_coef_commit,
    output i_samples_x_in, i_samples_x_vld, i_predict_out_rdy,
    input  o_samples_x_rdy, o_predict_out, o_predict_out_vld, o_predict_ovf
  );
endinterface

// File: rtl/linear_regression_predict_mv_mac.sv
// Registered signed multiply-accumulate: load seeds the accumulator, step adds a*b.
module lr_mac_unit #(
  parameter int N    = 32,
  parameter int ACCW = 67
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_load,
  input  logic signed [ACCW-1:0] i_load_val,
  input  logic                   i_step,
  input  logic signed [N-1:0]    i_a,
  input  logic signed [N-1:0]    i_b,
  output logic signed [ACCW-1:0] o_sum
);
  logic signed [ACCW-1:0]  r_acc;
  logic signed [2*N-1:0]   w_a_ext;
  logic signed [2*N-1:0]   w_b_ext;
  logic signed [2*N-1:0]   w_prod;
  logic signed [ACCW-1:0]  w_sum;

  assign w_a_ext = {{N{i_a[N-1]}}, i_a};
  assign w_b_ext = {{N{i_b[N-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_sum   = r_acc + {{(ACCW-2*N){w_prod[2*N-1]}}, w_prod};
  assign o_sum   = w_sum;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) r_acc <= '0;
    else if (i_load)        r_acc <= i_load_val;
    else if (i_step)        r_acc <= w_sum;
  end
endmodule

// File: rtl/linear_regression_predict_mv.sv
// y = theta0 + sum(theta_k * x_k) over K features with one shared multiplier.
// LR_PRED_SAT_EN: clamp out-of-range results instead of wrapping.
//   state   | meaning
//   IDLE    | waiting for a vector; applies a pending coefficient commit first
//   MAC     | one multiply-accumulate per cycle, K cycles
//   OUT     | result valid, held until the sink accepts it
module linear_regression_predict_mv
  import lr_pkg::*;
#(
  parameter int N    = LR_N_DEF,
  parameter int K    = LR_K_DEF,
  parameter int FRAC = LR_FRAC_DEF
) (
  input logic                         i_clock,
  input logic                         i_reset,
  linear_regression_predict_mv_if.slave io_bus
);
  localparam int ACCW = lr_acc_w(N, K);
  localparam int IW   = (K > 1) ? $clog2(K) : 1;
`ifdef LR_PRED_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  lr_state_t              r_state, w_state_nx;
  logic [N-1:0]           r_shadow [K+1];
  logic [N-1:0]           r_active [K+1];
  logic [N-1:0]           w_shadow_nx [K+1];
  logic                   r_pend;
  logic [K*N-1:0]         r_x;
  logic [IW-1:0]          r_idx;
  logic [N-1:0]           r_predict_out;
  logic                   r_ovf;
  logic                   w_rdy, w_vld, w_accept, w_copy, w_step, w_last, w_clear;
  logic [N-1:0]           w_theta, w_xk;
  logic signed [ACCW-1:0] w_sum, w_load_val, w_shift;
  logic signed [LR_MAXW-1:0] w_wide;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_rdy      = 1'b0;
    w_vld      = 1'b0;
    w_accept   = 1'b0;
    w_copy     = 1'b0;
    w_step     = 1'b0;
    w_last     = 1'b0;
    w_clear    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rdy    = !r_pend && !i_reset;
        w_copy   = r_pend;
        w_accept = w_rdy && io_bus.i_samples_x_vld;
        if (w_accept) w_state_nx = ST_MAC;
      end
      ST_MAC: begin
        w_step = 1'b1;
        w_last = (r_idx == IW'(K - 1));
        if (w_last) w_state_nx = ST_OUT;
      end
      ST_OUT: begin
        w_vld = 1'b1;
        if (io_bus.i_predict_out_rdy) begin
          w_clear    = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // A write landing in the copy cycle is folded into the copied bank.
  always_comb begin
    for (int k = 0; k <= K; k++) begin
      w_shadow_nx[k] = r_shadow[k];
      if (io_bus.i_coef_wr && int'(io_bus.i_coef_addr) == k) w_shadow_nx[k] = io_bus.i_coef_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k <= K; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
      r_pend <= 1'b0;
    end else begin
      for (int k = 0; k <= K; k++) begin
        r_shadow[k] <= w_shadow_nx[k];
        if (w_copy) r_active[k] <= w_shadow_nx[k];
      end
      r_pend <= io_bus.i_coef_commit | (r_pend & !w_copy);
    end
  end

  always_comb begin
    w_theta = r_active[1];
    w_xk    = r_x[N-1:0];
    for (int k = 0; k < K; k++) begin
      if (r_idx == IW'(k)) begin
        w_theta = r_active[k+1];
        w_xk    = r_x[k*N +: N];
      end
    end
  end

  assign w_load_val = $signed({{(ACCW-N){r_active[0][N-1]}}, r_active[0]}) <<< FRAC;
  assign w_shift    = w_sum >>> FRAC;
  assign w_wide     = {{(LR_MAXW-ACCW){w_shift[ACCW-1]}}, w_shift};

  lr_mac_unit #(.N(N), .ACCW(ACCW)) u_mac (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (w_clear),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_step     (w_step),
    .i_a        (w_theta),
    .i_b        (w_xk),
    .o_sum      (w_sum)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_x           <= '0;
      r_idx         <= '0;
      r_predict_out <= '0;
      r_ovf         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x   <= io_bus.i_samples_x_in;
        r_idx <= '0;
      end
      if (w_step) r_idx <= r_idx + IW'(1);
      if (w_last) begin
        r_predict_out <= N'(lr_fit(w_wide, N, SAT));
        r_ovf         <= lr_is_ovf(w_wide, N);
      end
    end
  end

  assign io_bus.o_samples_x_rdy   = w_rdy;
  assign io_bus.o_predict_out_vld = w_vld;
  assign io_bus.o_predict_out     = r_predict_out;
  assign io_bus.o_predict_ovf     = r_ovf;
endmodule

// File: tb/tb_linear_regression_predict_mv.sv
// Bench for linear_regression_predict_mv: a K=1/FRAC=0 instance and a K=4/FRAC=8 instance.
module tb_linear_regression_predict_mv;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  linear_regression_predict_mv_if #(.N(32), .K(1)) bus_a ();
  linear_regression_predict_mv_if #(.N(32), .K(4)) bus_b ();

  linear_regression_predict_mv #(.N(32), .K(1), .FRAC(0)) dut_a (
    .i_clock(clk), .i_reset(rst_a), .io_bus(bus_a));
  linear_regression_predict_mv #(.N(32), .K(4), .FRAC(8)) dut_b (
    .i_clock(clk), .i_reset(rst_b), .io_bus(bus_b));

`ifdef LR_PRED_SAT_EN
  localparam logic [31:0] EXP_POS = 32'h7FFFFFFF;
  localparam logic [31:0] EXP_NEG = 32'h80000000;
`else
  localparam logic [31:0] EXP_POS = 32'h80000000;
  localparam logic [31:0] EXP_NEG = 32'h7FFFFFFF;
`endif

  typedef struct {
    logic [4:0][31:0] th;
    logic [3:0][31:0] x;
    logic [31:0]      y;
    logic             ovf;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // Reference: exact sum in wide arithmetic, floor-scaled, then range-checked.
  function automatic void model(input logic [4:0][31:0] th, input logic [3:0][31:0] xv,
                                output logic [31:0] y, output logic ov);
    logic signed [127:0] acc, r;
    acc = 128'($signed(th[0])) * 128'sd256;
    for (int k = 0; k < 4; k++)
      acc = acc + 128'($signed(th[k+1])) * 128'($signed(xv[k]));
    r  = acc >>> 8;
    ov = (r > 128'sd2147483647) || (r < -128'sd2147483648);
    y  = r[31:0];
`ifdef LR_PRED_SAT_EN
    if (ov) y = r[127] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
  endfunction

  function automatic logic [31:0] rnd32();
    if ($urandom_range(0, 1) == 1) return $urandom;
    return 32'($urandom_range(0, 4000)) - 32'd2000;
  endfunction

  task automatic a_load(input logic [1:0][31:0] th);
    for (int k = 0; k < 2; k++) begin
      bus_a.i_coef_wr = 1'b1; bus_a.i_coef_addr = 1'(k); bus_a.i_coef_data = th[k];
      @(negedge clk);
    end
    bus_a.i_coef_wr = 1'b0; bus_a.i_coef_commit = 1'b1;
    @(negedge clk);
    bus_a.i_coef_commit = 1'b0;
  endtask

  task automatic a_predict(input logic [31:0] xv, output logic [31:0] y, output logic ov,
                           output int lat);
    int t = 0;
    while (!bus_a.o_samples_x_rdy && t < 100) begin @(negedge clk); t++; end
    chk1("a_rdy_wait", bus_a.o_samples_x_rdy, 1'b1);
    bus_a.i_samples_x_in = xv; bus_a.i_samples_x_vld = 1'b1;
    @(negedge clk);
    bus_a.i_samples_x_vld = 1'b0;
    lat = 0;
    while (!bus_a.o_predict_out_vld && lat < 100) begin @(negedge clk); lat++; end
    y = bus_a.o_predict_out; ov = bus_a.o_predict_ovf;
    @(negedge clk);
  endtask

  task automatic b_load(input logic [4:0][31:0] th);
    for (int k = 0; k < 5; k++) begin
      bus_b.i_coef_wr = 1'b1; bus_b.i_coef_addr = 3'(k); bus_b.i_coef_data = th[k];
      @(negedge clk);
    end
    bus_b.i_coef_wr = 1'b0; bus_b.i_coef_commit = 1'b1;
    @(negedge clk);
    bus_b.i_coef_commit = 1'b0;
  endtask

  task automatic b_send(input logic [3:0][31:0] xv);
    int t = 0;
    while (!bus_b.o_samples_x_rdy && t < 100) begin @(negedge clk); t++; end
    chk1("b_rdy_wait", bus_b.o_samples_x_rdy, 1'b1);
    bus_b.i_samples_x_in = xv; bus_b.i_samples_x_vld = 1'b1;
    @(negedge clk);
    bus_b.i_samples_x_vld = 1'b0;
  endtask

  task automatic b_wait(output logic [31:0] y, output logic ov, output int lat);
    lat = 0;
    while (!bus_b.o_predict_out_vld && lat < 100) begin @(negedge clk); lat++; end
    y = bus_b.o_predict_out; ov = bus_b.o_predict_ovf;
  endtask

  task automatic b_predict(input logic [3:0][31:0] xv, output logic [31:0] y, output logic ov,
                           output int lat);
    b_send(xv);
    b_wait(y, ov, lat);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] y, ey;
    logic ov, eov, stable, seen;
    int lat;
    logic [4:0][31:0] th;
    logic [3:0][31:0] xv;

    tbl[0] = '{th: {32'd0, 32'd128, 32'hFFFFFF00, 32'd512, 32'd256},
               x: {32'd256, 32'd256, 32'd256, 32'd256}, y: 32'd640, ovf: 1'b0};
    tbl[1] = '{th: {32'd256, 32'd256, 32'd256, 32'd256, 32'd0},
               x: {32'd4, 32'd3, 32'd2, 32'd1}, y: 32'd10, ovf: 1'b0};
    tbl[2] = '{th: {32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFF00},
               x: {32'd8, 32'd7, 32'd6, 32'd5}, y: 32'hFFFFFF00, ovf: 1'b0};
    tbl[3] = '{th: {32'd0, 32'd0, 32'd0, 32'd1, 32'd0},
               x: {32'd0, 32'd0, 32'd0, 32'hFFFFFFFF}, y: 32'hFFFFFFFF, ovf: 1'b0};
    tbl[4] = '{th: {32'd0, 32'd0, 32'd0, 32'd1, 32'd0},
               x: {32'd0, 32'd0, 32'd0, 32'd255}, y: 32'd0, ovf: 1'b0};

    bus_a.i_coef_wr = 0; bus_a.i_coef_addr = '0; bus_a.i_coef_data = '0; bus_a.i_coef_commit = 0;
    bus_a.i_samples_x_in = '0; bus_a.i_samples_x_vld = 0; bus_a.i_predict_out_rdy = 1;
    bus_b.i_coef_wr = 0; bus_b.i_coef_addr = '0; bus_b.i_coef_data = '0; bus_b.i_coef_commit = 0;
    bus_b.i_samples_x_in = '0; bus_b.i_samples_x_vld = 0; bus_b.i_predict_out_rdy = 1;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_a_rdy", bus_a.o_samples_x_rdy, 1'b0);
    chk1("rst_b_rdy", bus_b.o_samples_x_rdy, 1'b0);
    chk1("rst_b_vld", bus_b.o_predict_out_vld, 1'b0);
    chk("rst_b_out", bus_b.o_predict_out, 32'd0);
    chk1("rst_b_ovf", bus_b.o_predict_ovf, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk1("post_rst_a_rdy", bus_a.o_samples_x_rdy, 1'b1);
    chk1("post_rst_b_rdy", bus_b.o_samples_x_rdy, 1'b1);

    // K=1 basic and range boundaries
    a_load({32'd1111, 32'd69403});
    a_predict(32'd10, y, ov, lat);
    chk("a_basic", y, 32'd80513);
    chk("a_latency", 32'(lat), 32'd1);
    a_load({32'd1, 32'h7FFFFFFF});
    a_predict(32'd1, y, ov, lat);
    chk("a_pos_ovf_val", y, EXP_POS);
    chk1("a_pos_ovf_flag", ov, 1'b1);
    a_load({32'hFFFFFFFF, 32'h80000000});
    a_predict(32'd1, y, ov, lat);
    chk("a_neg_ovf_val", y, EXP_NEG);
    chk1("a_neg_ovf_flag", ov, 1'b1);
    a_load({32'd1, 32'h7FFFFFFE});
    a_predict(32'd1, y, ov, lat);
    chk("a_max_val", y, 32'h7FFFFFFF);
    chk1("a_max_flag", ov, 1'b0);

    // K=4 table
    for (int i = 0; i < 5; i++) begin
      b_load(tbl[i].th);
      b_predict(tbl[i].x, y, ov, lat);
      chk($sformatf("tbl%0d_val", i), y, tbl[i].y);
      chk1($sformatf("tbl%0d_ovf", i), ov, tbl[i].ovf);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd4);
    end

    // Sink back-pressure with the next vector already offered
    b_load(tbl[0].th);
    bus_b.i_predict_out_rdy = 1'b0;
    b_send(tbl[0].x);
    b_wait(y, ov, lat);
    chk("bp_first", y, 32'd640);
    bus_b.i_samples_x_in = tbl[1].x; bus_b.i_samples_x_vld = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_b.o_predict_out !== 32'd640 || bus_b.o_predict_out_vld !== 1'b1 ||
          bus_b.o_samples_x_rdy !== 1'b0) stable = 1'b0;
    end
    chk1("bp_hold_stable", stable, 1'b1);
    bus_b.i_predict_out_rdy = 1'b1;
    @(negedge clk);
    chk1("bp_vld_drop", bus_b.o_predict_out_vld, 1'b0);
    chk1("bp_rdy_after_hs", bus_b.o_samples_x_rdy, 1'b1);
    @(negedge clk);
    chk1("bp_taken", bus_b.o_samples_x_rdy, 1'b0);
    bus_b.i_samples_x_vld = 1'b0;
    b_wait(y, ov, lat);
    chk("bp_second", y, 32'd257);
    chk("bp_second_lat", 32'(lat), 32'd4);
    @(negedge clk);

    // Commit while busy: in-flight result keeps old theta1
    b_load({32'd0, 32'd0, 32'd0, 32'd256, 32'd0});
    b_send({32'd0, 32'd0, 32'd0, 32'd256});
    bus_b.i_coef_wr = 1'b1; bus_b.i_coef_addr = 3'd1; bus_b.i_coef_data = 32'd2;
    bus_b.i_coef_commit = 1'b1;
    @(negedge clk);
    bus_b.i_coef_wr = 1'b0; bus_b.i_coef_commit = 1'b0;
    b_wait(y, ov, lat);
    chk("commit_old", y, 32'd256);
    @(negedge clk);
    chk1("commit_rdy_low", bus_b.o_samples_x_rdy, 1'b0);
    @(negedge clk);
    chk1("commit_rdy_back", bus_b.o_samples_x_rdy, 1'b1);
    b_predict({32'd0, 32'd0, 32'd0, 32'd256}, y, ov, lat);
    chk("commit_new", y, 32'd2);

    // Reset in the middle of a computation
    b_load(tbl[0].th);
    b_send(tbl[0].x);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk1("midrst_vld", bus_b.o_predict_out_vld, 1'b0);
    chk1("midrst_rdy", bus_b.o_samples_x_rdy, 1'b0);
    chk("midrst_out", bus_b.o_predict_out, 32'd0);
    rst_b = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus_b.o_predict_out_vld) seen = 1'b1;
    end
    chk1("midrst_no_vld", seen, 1'b0);
    chk1("midrst_rdy_back", bus_b.o_samples_x_rdy, 1'b1);
    b_predict(tbl[0].x, y, ov, lat);
    chk("midrst_zero", y, 32'd0);
    chk1("midrst_zero_ovf", ov, 1'b0);

    // Randomized against the reference model
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 5; k++) th[k] = rnd32();
      for (int k = 0; k < 4; k++) xv[k] = rnd32();
      b_load(th);
      b_predict(xv, y, ov, lat);
      model(th, xv, ey, eov);
      chk($sformatf("rnd%0d_val", i), y, ey);
      chk1($sformatf("rnd%0d_ovf", i), ov, eov);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
